// File: rtl/uart_tx_if.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_if
// Brief    : Byte handshake between the host byte source and uart_tx.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module   : uart_tx
// Brief    : 8N1/8N2 UART transmitter with internal baud divider and
//            valid/ready byte intake; tx is a registered output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 38400000,
    parameter int STOP_BITS  = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  soft_reset,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                 c_DIV       = CLOCK_FREQ / BAUD_RATE;
    localparam int                 c_CNT_W     = (c_DIV >= 2) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);
    localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

    if (c_DIV < 2) begin : g_div_check
        $error("uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [c_CNT_W-1:0] w_baud_nxt;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         w_bit_nxt;
    logic [2:0]         w_bit_inc;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_baud_end;

    assign w_accept   = bus.valid && (r_state == S_IDLE);
    assign w_baud_end = (r_baud_cnt == c_BAUD_LAST);
    assign w_bit_inc  = r_bit_cnt + 3'd1;

    assign bus.ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign tx        = r_tx;
    assign done      = r_done;

    // Next-state logic also produces the next tx level so the pin is a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;

        if (soft_reset) begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tx_nxt = 1'b1;
                    if (w_accept) begin
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                        w_baud_nxt  = '0;
                        w_bit_nxt   = '0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        w_state_nxt = S_DATA;
                        w_baud_nxt  = '0;
                        w_tx_nxt    = r_shift[0];
                    end else begin
                        w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        w_baud_nxt = '0;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_STOP;
                            w_bit_nxt   = '0;
                            w_tx_nxt    = 1'b1;
                        end else begin
                            w_bit_nxt = w_bit_inc;
                            w_tx_nxt  = r_shift[w_bit_inc];
                        end
                    end else begin
                        w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    // bit_cnt is reused to count stop bits.
                    if (w_baud_end) begin
                        w_baud_nxt = '0;
                        if (r_bit_cnt == c_STOP_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_bit_nxt   = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_bit_nxt = w_bit_inc;
                        end
                    end else begin
                        w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
            if (w_accept && !soft_reset) begin
                r_shift <= bus.data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx (DIV=16, one instance per stop-bit count).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

    localparam int DIV = 16;

    typedef logic [3:0] obs_t;   // {tx, ready, busy, done}

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic soft1 = 1'b0;
    logic soft2 = 1'b0;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;

    int checks = 0;
    int errors = 0;

    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .soft_reset(soft1), .bus(bus1.slave),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .soft_reset(soft2), .bus(bus2.slave),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            bus1.valid = v;
            bus1.data  = d;
        end else begin
            bus2.valid = v;
            bus2.data  = d;
        end
    endtask

    function automatic obs_t sample(input int sel);
        if (sel == 0) return {tx1, bus1.ready, busy1, done1};
        return {tx2, bus2.ready, busy2, done2};
    endfunction

    // Records n cycles; with noise, valid toggles randomly while the DUT is busy.
    task automatic capture(input int sel, input int n, input bit noise, output obs_t q[$]);
        q = {};
        for (int i = 0; i < n; i++) begin
            q.push_back(sample(sel));
            if (noise) drive(sel, (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
            step();
        end
    endtask

    // Reference: frame = start(0), 8 data LSB first, s stop(1), DIV cycles per bit,
    // followed by one idle cycle carrying the done pulse.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [7:0] v;
        v = b;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v[idx-1];
        return 1'b1;
    endfunction

    task automatic model_frame(input logic [7:0] b, input int s, output obs_t q[$]);
        q = {};
        for (int k = 0; k < (9 + s) * DIV; k++) q.push_back({frame_bit(b, k / DIV), 3'b010});
        q.push_back(4'b1101);
    endtask

    function automatic logic [7:0] decode(input obs_t q[$], input int off);
        logic [7:0] r;
        obs_t       o;
        for (int i = 0; i < 8; i++) begin
            o    = q[off + DIV * (i + 1) + DIV / 2];
            r[i] = o[3];
        end
        return r;
    endfunction

    task automatic test_reset();
        obs_t o;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        step();
        o = sample(0);
        checks++;
        if (o !== 4'b1100) begin
            errors++;
            $display("FAIL reset_held got %b want 1100", o);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                o = sample(s);
                checks++;
                if (o !== 4'b1100) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cyc %0d got %b want 1100", s + 1, c, o);
                end
            end
        end
    endtask

    task automatic test_frame(input int sel, input logic [7:0] b);
        obs_t q[$];
        obs_t e[$];
        obs_t o;
        int   s;
        s = (sel == 0) ? 1 : 2;
        drive(sel, 1'b1, b);
        o = sample(sel);
        checks++;
        if (o !== 4'b1100) begin
            errors++;
            $display("FAIL frame_pre %h got %b want 1100", b, o);
        end
        step();
        drive(sel, 1'b0, 8'($urandom));
        capture(sel, (9 + s) * DIV + 1, 1'b1, q);
        model_frame(b, s, e);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (q[k] !== e[k]) begin
                errors++;
                $display("FAIL frame_%h stop%0d cyc %0d got %b want %b", b, s, k, q[k], e[k]);
            end
        end
        checks++;
        if (decode(q, 0) !== b) begin
            errors++;
            $display("FAIL frame_rx got %h want %h", decode(q, 0), b);
        end
        o = sample(sel);
        checks++;
        if (o !== 4'b1100) begin
            errors++;
            $display("FAIL frame_post %h got %b want 1100", b, o);
        end
    endtask

    task automatic test_back_to_back();
        obs_t q1[$];
        obs_t q2[$];
        obs_t qa[$];
        obs_t e[$];
        int   fall;
        drive(0, 1'b1, 8'h00);
        step();
        drive(0, 1'b1, 8'h55);
        capture(0, 10 * DIV + 1, 1'b0, q1);
        drive(0, 1'b0, 8'h00);
        capture(0, 10 * DIV + 1, 1'b0, q2);
        qa = {q1, q2};
        model_frame(8'h00, 1, e);
        model_frame(8'h55, 1, q1);
        e = {e, q1};
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (qa[k] !== e[k]) begin
                errors++;
                $display("FAIL b2b cyc %0d got %b want %b", k, qa[k], e[k]);
            end
        end
        fall = -1;
        for (int k = 1; k < qa.size(); k++) begin
            if (fall < 0 && qa[k-1][3] == 1'b1 && qa[k][3] == 1'b0) fall = k;
        end
        checks++;
        if (fall !== 10 * DIV + 1) begin
            errors++;
            $display("FAIL b2b_period got %0d want %0d", fall, 10 * DIV + 1);
        end
        checks++;
        if (decode(qa, 0) !== 8'h00 || decode(qa, 10 * DIV + 1) !== 8'h55) begin
            errors++;
            $display("FAIL b2b_rx got %h,%h want 00,55", decode(qa, 0), decode(qa, 10 * DIV + 1));
        end
    endtask

    task automatic test_soft_reset();
        obs_t q[$];
        obs_t e[$];
        obs_t o;
        drive(0, 1'b1, 8'h3C);
        step();
        drive(0, 1'b0, 8'h00);
        capture(0, 50, 1'b0, q);
        model_frame(8'h3C, 1, e);
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (q[k] !== e[k]) begin
                errors++;
                $display("FAIL soft_prefix cyc %0d got %b want %b", k, q[k], e[k]);
            end
        end
        soft1 = 1'b1;
        step();
        soft1 = 1'b0;
        o = sample(0);
        checks++;
        if (o !== 4'b1100) begin
            errors++;
            $display("FAIL soft_abort got %b want 1100", o);
        end
        capture(0, 200, 1'b0, q);
        for (int k = 0; k < 200; k++) begin
            checks++;
            if (q[k] !== 4'b1100) begin
                errors++;
                $display("FAIL soft_no_done cyc %0d got %b want 1100", k, q[k]);
            end
        end
        drive(0, 1'b1, 8'($urandom));
        soft1 = 1'b1;
        step();
        soft1 = 1'b0;
        drive(0, 1'b0, 8'h00);
        capture(0, 3, 1'b0, q);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q[k] !== 4'b1100) begin
                errors++;
                $display("FAIL soft_discard cyc %0d got %b want 1100", k, q[k]);
            end
        end
        test_frame(0, 8'hC3);
    endtask

    task automatic test_async_rst();
        obs_t q[$];
        obs_t o;
        drive(0, 1'b1, 8'($urandom_range(0, 127)));
        step();
        drive(0, 1'b0, 8'h00);
        capture(0, 60, 1'b0, q);
        #3;
        rst = 1'b1;
        #1;
        o = sample(0);
        checks++;
        if (o !== 4'b1100) begin
            errors++;
            $display("FAIL rst_async got %b want 1100", o);
        end
        step();
        rst = 1'b0;
        step();
        o = sample(0);
        checks++;
        if (o !== 4'b1100) begin
            errors++;
            $display("FAIL rst_release got %b want 1100", o);
        end
        test_frame(0, 8'h81);
    endtask

    task automatic test_random();
        obs_t q[$];
        int   sel;
        int   gap;
        for (int it = 0; it < 8; it++) begin
            sel = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 5));
            capture(sel, gap, 1'b0, q);
            for (int k = 0; k < gap; k++) begin
                checks++;
                if (q[k] !== 4'b1100) begin
                    errors++;
                    $display("FAIL rand_gap it %0d cyc %0d got %b want 1100", it, k, q[k]);
                end
            end
            test_frame(sel, 8'($urandom));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.valid = 1'b0;
        bus1.data  = 8'h00;
        bus2.valid = 1'b0;
        bus2.data  = 8'h00;
        test_reset();
        test_frame(0, 8'hA5);
        test_back_to_back();
        test_frame(1, 8'hFF);
        test_soft_reset();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
